// File: rtl/spi_temp_reader.sv
// SPI temperature sensor reader: one mode-0 frame per count==TRIG_VALUE edge, sign-extended result.
// Optional TEMP_AVG_EN: report the average of every four frames instead of each frame.
module spi_temp_reader #(
    parameter logic [23:0] TRIG_VALUE = 24'h100,
    parameter int          CLK_DIV    = 4,
    parameter int          FRAME_BITS = 16,
    parameter int          TEMP_MSB   = 15,
    parameter int          TEMP_LSB   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] count,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        busy,
    output logic        trig_miss
);
    localparam int FW = TEMP_MSB - TEMP_LSB + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]            st_r;
    logic [DW-1:0]         div_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [FRAME_BITS-1:0] shreg_r;
    logic                  prev_match_r;
    logic                  trig_s;
    logic                  div_done_s;
    logic signed [FW-1:0]  field_s;
    logic signed [15:0]    ext_s;

    assign trig_s     = (count == TRIG_VALUE) && !prev_match_r;
    assign div_done_s = (div_cnt_r == DIV_LAST);
    assign field_s    = shreg_r[TEMP_MSB:TEMP_LSB];
    assign ext_s      = 16'(field_s);

`ifdef TEMP_AVG_EN
    logic signed [17:0] acc_r;
    logic signed [17:0] acc_next_s;
    logic [1:0]         avg_cnt_r;

    assign acc_next_s = acc_r + 18'(ext_s);
`endif

    // Edge-qualify the trigger (flag resets high so a count parked at TRIG_VALUE cannot fire) and flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_match_r <= 1'b1;
            trig_miss    <= 1'b0;
        end else begin
            prev_match_r <= (count == TRIG_VALUE);
            trig_miss    <= trig_s && busy;
        end
    end

    // Frame sequencer: CS setup, SCLK generation with MSB-first capture, CS hold, result load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r       <= ST_IDLE;
            div_cnt_r  <= '0;
            bit_cnt_r  <= '0;
            shreg_r    <= '0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            temp_data  <= 16'h0000;
            temp_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef TEMP_AVG_EN
            acc_r      <= 18'sd0;
            avg_cnt_r  <= 2'd0;
`endif
        end else begin
            temp_valid <= 1'b0;
            case (st_r)
                ST_IDLE: begin
                    div_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    // busy still reads high in the result cycle, so a trigger there is a miss
                    if (trig_s && !busy) begin
                        st_r     <= ST_SETUP;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        busy     <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (div_done_s) begin
                        st_r      <= ST_SHIFT;
                        div_cnt_r <= '0;
                        spi_sclk  <= 1'b1;
                        shreg_r   <= {shreg_r[FRAME_BITS-2:0], spi_miso};
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (div_done_s) begin
                        div_cnt_r <= '0;
                        if (spi_sclk) begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt_r == BIT_LAST) begin
                                st_r <= ST_HOLD;
                            end else begin
                                st_r <= ST_SHIFT;
                            end
                        end else begin
                            spi_sclk  <= 1'b1;
                            shreg_r   <= {shreg_r[FRAME_BITS-2:0], spi_miso};
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1);
                    end
                end
                ST_HOLD: begin
                    if (div_done_s) begin
                        st_r     <= ST_IDLE;
                        spi_cs_n <= 1'b1;
`ifdef TEMP_AVG_EN
                        if (avg_cnt_r == 2'd3) begin
                            temp_valid <= 1'b1;
                            temp_data  <= 16'(acc_next_s >>> 2);
                            acc_r      <= 18'sd0;
                            avg_cnt_r  <= 2'd0;
                        end else begin
                            acc_r      <= acc_next_s;
                            avg_cnt_r  <= avg_cnt_r + 2'd1;
                        end
`else
                        temp_valid <= 1'b1;
                        temp_data  <= ext_s;
`endif
                    end else begin
                        div_cnt_r <= div_cnt_r + DW'(1);
                    end
                end
                default: begin
                    st_r     <= ST_IDLE;
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_temp_reader.sv
// Directed self-checking bench for spi_temp_reader: frame timing, sign extension,
// trigger qualification, dropped triggers, mid-frame reset and (TEMP_AVG_EN) averaging.
module tb_spi_temp_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] count = 24'h000000;
    logic        spi_miso = 1'b0;
    logic        spi_cs_n, spi_sclk, temp_valid, busy, trig_miss;
    logic [15:0] temp_data;

    int total = 0;
    int bad = 0;

    logic [15:0] frame_word = 16'h0000;
    int          rises_seen = 0;
    logic        sclk_q = 1'b0;

    int          m_cs_low, m_first_rise, m_last_rise, m_last_fall, m_cs_high;
    int          m_valid_at, m_rises, m_valids, m_misses, m_miss_at;
    logic [15:0] m_data;
    logic        m_busy_valid, m_busy_after;

    spi_temp_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count      (count),
        .spi_miso   (spi_miso),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .busy       (busy),
        .trig_miss  (trig_miss)
    );

    always #5 clk = ~clk;

    // Sensor model: presents frame_word MSB first, advancing after each observed SCLK rise.
    always @(negedge clk) begin
        if (spi_cs_n) begin
            rises_seen = 0;
        end else if (spi_sclk && !sclk_q) begin
            rises_seen = rises_seen + 1;
        end
        sclk_q = spi_sclk;
        spi_miso = (rises_seen < 16) ? frame_word[15 - rises_seen] : 1'b0;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Makes the current cycle "cycle 0" of a fresh trigger edge.
    task automatic fire(input logic [15:0] word);
        frame_word = word;
        count = 24'h0000FF;
        step();
        count = 24'h000100;
    endtask

    // Observes cycles 1..ncyc; count is TRIG_VALUE in cycle retrig_at, or always when hold=1.
    task automatic run(input int ncyc, input int retrig_at, input bit hold);
        logic pcs, psclk;
        m_cs_low = -1; m_first_rise = -1; m_last_rise = -1; m_last_fall = -1;
        m_cs_high = -1; m_valid_at = -1; m_rises = 0; m_valids = 0;
        m_misses = 0; m_miss_at = -1; m_data = 16'h0000;
        m_busy_valid = 1'b0; m_busy_after = 1'b1;
        pcs = spi_cs_n;
        psclk = spi_sclk;
        for (int n = 1; n <= ncyc; n++) begin
            step();
            if (!spi_cs_n && pcs && m_cs_low < 0) m_cs_low = n;
            if (spi_cs_n && !pcs && m_cs_high < 0) m_cs_high = n;
            if (spi_sclk && !psclk) begin
                m_rises++;
                if (m_first_rise < 0) m_first_rise = n;
                m_last_rise = n;
            end
            if (!spi_sclk && psclk) m_last_fall = n;
            if (temp_valid) begin
                m_valids++;
                if (m_valid_at < 0) begin
                    m_valid_at = n;
                    m_data = temp_data;
                    m_busy_valid = busy;
                end
            end
            if (m_valid_at >= 0 && n == m_valid_at + 1) m_busy_after = busy;
            if (trig_miss) begin
                m_misses++;
                m_miss_at = n;
            end
            pcs = spi_cs_n;
            psclk = spi_sclk;
            if (hold || n == retrig_at) count = 24'h000100;
            else count = 24'h000101;
        end
    endtask

    task automatic test_reset();
        count = 24'h000100;
        step();
        total++;
        if ({spi_cs_n, spi_sclk, temp_valid, busy, trig_miss} !== 5'b10000 || temp_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: cs_n=%b sclk=%b valid=%b busy=%b miss=%b data=%h, required 1 0 0 0 0 0000",
                     spi_cs_n, spi_sclk, temp_valid, busy, trig_miss, temp_data);
        end
        // Release with count parked at TRIG_VALUE: must not fire.
        rst_n = 1'b1;
        run(20, -1, 1'b1);
        total++;
        if (m_cs_low != -1) begin
            bad++;
            $display("FAIL reset_parked_count: cs_n fell at cycle %0d, required no frame", m_cs_low);
        end
    endtask

`ifndef TEMP_AVG_EN
    task automatic test_basic_frame();
        fire(16'h0C80);
        run(140, -1, 1'b0);
        total++;
        if (m_cs_low != 1) begin
            bad++; $display("FAIL cs_fall: cycle %0d, required 1", m_cs_low);
        end
        total++;
        if (m_first_rise - m_cs_low != 4) begin
            bad++; $display("FAIL cs_setup: %0d clk, required 4", m_first_rise - m_cs_low);
        end
        total++;
        if (m_rises != 16 || m_last_rise != 125) begin
            bad++; $display("FAIL sclk_rises: count=%0d last=%0d, required 16 last=125", m_rises, m_last_rise);
        end
        total++;
        if (m_last_fall != 129 || m_cs_high - m_last_fall != 4) begin
            bad++; $display("FAIL cs_hold: sclk low at %0d cs_n high at %0d, required 129 and 133", m_last_fall, m_cs_high);
        end
        total++;
        if (m_valid_at != 133 || m_valids != 1) begin
            bad++; $display("FAIL latency: valid at %0d (%0d pulses), required 133 (1)", m_valid_at, m_valids);
        end
        total++;
        if (m_data !== 16'h0190) begin
            bad++; $display("FAIL data_pos: got %h, required 0190", m_data);
        end
        total++;
        if (m_busy_valid !== 1'b1 || m_busy_after !== 1'b0) begin
            bad++; $display("FAIL busy_window: at valid=%b after=%b, required 1 0", m_busy_valid, m_busy_after);
        end
        total++;
        if (temp_data !== 16'h0190) begin
            bad++; $display("FAIL data_hold: got %h, required 0190", temp_data);
        end
    endtask

    task automatic test_negative();
        fire(16'hFFF8);
        run(140, -1, 1'b0);
        total++;
        if (m_valids != 1 || m_data !== 16'hFFFF) begin
            bad++; $display("FAIL data_neg: got %h (%0d pulses), required FFFF (1)", m_data, m_valids);
        end
        fire(16'hE408);
        run(140, -1, 1'b0);
        total++;
        if (m_data !== 16'hFC81) begin
            bad++; $display("FAIL data_neg2: got %h, required FC81", m_data);
        end
    endtask

    task automatic test_held_count();
        fire(16'h0C80);
        run(500, -1, 1'b1);
        total++;
        if (m_rises != 16 || m_valids != 1 || m_misses != 0) begin
            bad++; $display("FAIL held_count: rises=%0d valids=%0d misses=%0d, required 16 1 0", m_rises, m_valids, m_misses);
        end
    endtask

    task automatic test_miss();
        fire(16'h0C88);
        run(140, 50, 1'b0);
        total++;
        if (m_misses != 1 || m_miss_at != 51) begin
            bad++; $display("FAIL miss_pulse: %0d pulses at %0d, required 1 at 51", m_misses, m_miss_at);
        end
        total++;
        if (m_rises != 16 || m_valids != 1 || m_valid_at != 133 || m_data !== 16'h0191) begin
            bad++; $display("FAIL miss_frame: rises=%0d valid=%0d@%0d data=%h, required 16 1@133 0191",
                            m_rises, m_valids, m_valid_at, m_data);
        end
    endtask

    task automatic test_back_to_back();
        fire(16'h0C90);
        run(140, 133, 1'b0);
        total++;
        if (m_misses != 1 || m_miss_at != 134 || m_data !== 16'h0192) begin
            bad++; $display("FAIL valid_cycle_trig: misses=%0d at %0d data=%h, required 1 at 134 0192",
                            m_misses, m_miss_at, m_data);
        end
        total++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL valid_cycle_idle: cs_n=%b busy=%b, required 1 0", spi_cs_n, busy);
        end
    endtask

    task automatic test_reset_midframe();
        fire(16'h0C98);
        run(60, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL async_reset: cs_n=%b sclk=%b busy=%b, required 1 0 0", spi_cs_n, spi_sclk, busy);
        end
        step();
        step();
        rst_n = 1'b1;
        run(200, -1, 1'b0);
        total++;
        if (m_valids != 0 || m_cs_low != -1) begin
            bad++; $display("FAIL reset_discard: valids=%0d cs_low=%0d, required 0 -1", m_valids, m_cs_low);
        end
        fire(16'h0C80);
        run(140, -1, 1'b0);
        total++;
        if (m_valid_at != 133 || m_data !== 16'h0190) begin
            bad++; $display("FAIL after_reset: valid at %0d data=%h, required 133 0190", m_valid_at, m_data);
        end
    endtask
`else
    task automatic test_average();
        logic [15:0] words [4];
        words[0] = 16'h0C80; words[1] = 16'h0C88; words[2] = 16'h0C90; words[3] = 16'h0C98;
        for (int f = 0; f < 4; f++) begin
            fire(words[f]);
            run(140, -1, 1'b0);
            total++;
            if (m_rises != 16 || m_valids != ((f == 3) ? 1 : 0)) begin
                bad++; $display("FAIL avg_frame%0d: rises=%0d valids=%0d", f, m_rises, m_valids);
            end
        end
        total++;
        if (m_valid_at != 133 || m_data !== 16'h0191) begin
            bad++; $display("FAIL avg_value: valid at %0d data=%h, required 133 0191", m_valid_at, m_data);
        end
        fire(16'hFFF8);
        run(140, -1, 1'b0);
        total++;
        if (m_valids != 0 || temp_data !== 16'h0191) begin
            bad++; $display("FAIL avg_restart: valids=%0d data=%h, required 0 0191", m_valids, temp_data);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef TEMP_AVG_EN
        test_basic_frame();
        test_negative();
        test_held_count();
        test_miss();
        test_back_to_back();
        test_reset_midframe();
`else
        test_average();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
